// File: rtl/alu_pkg.sv
// Shared constants and the decoded issue bundle type used by the ALU decode/issue slice.
package alu_pkg;

  // ALU operation codes seen by the execute stage
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_MUL  = 6'd2;
  localparam logic [5:0] ALU_DIV  = 6'd3;
  localparam logic [5:0] ALU_SLT  = 6'd4;
  localparam logic [5:0] ALU_SLL  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_AND  = 6'd8;
  localparam logic [5:0] ALU_OR   = 6'd9;
  localparam logic [5:0] ALU_XOR  = 6'd10;
  localparam logic [5:0] ALU_NOR  = 6'd11;
  localparam logic [5:0] ALU_LUI  = 6'd12;
  localparam logic [5:0] ALU_BEQZ = 6'd13;
  localparam logic [5:0] ALU_JALR = 6'd16;
  localparam logic [5:0] ALU_J    = 6'd17;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] SRC_B_RT    = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_SHAMT = 2'd2;

  typedef struct packed {
    logic [5:0]  alu_opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  src_b_sel;
    logic        reg_write;
    logic        illegal;
  } issue_bundle_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational MIPS instruction word to ALU issue bundle decoder; zero latency, no flow control.
// Unknown op/funct yields an ADD bundle flagged illegal with the raw fields passed through.
module mips_decode
  import alu_pkg::*;
(
  input  logic [31:0]   instr,
  output issue_bundle_t bundle
);

  logic [5:0]    op;
  logic [5:0]    fn;
  logic          itype;
  logic          itype_zext;
  logic          shift;
  issue_bundle_t b;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    b            = '0;
    b.alu_opcode = ALU_ADD;
    b.rs         = instr[25:21];
    b.rt         = instr[20:16];
    b.rd         = instr[15:11];
    b.imm        = sext16(instr[15:0]);
    b.src_b_sel  = SRC_B_RT;
    itype        = 1'b0;
    itype_zext   = 1'b0;
    shift        = 1'b0;

    case (op)
      OP_RTYPE: begin
        b.reg_write = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: b.alu_opcode = ALU_ADD;
          FN_SUB, FN_SUBU: b.alu_opcode = ALU_SUB;
          FN_AND:          b.alu_opcode = ALU_AND;
          FN_OR:           b.alu_opcode = ALU_OR;
          FN_XOR:          b.alu_opcode = ALU_XOR;
          FN_NOR:          b.alu_opcode = ALU_NOR;
          FN_SLT:          b.alu_opcode = ALU_SLT;
          FN_JALR:         b.alu_opcode = ALU_JALR;
          FN_SLL: begin
            b.alu_opcode = ALU_SLL;
            shift        = 1'b1;
          end
          FN_SRL: begin
            b.alu_opcode = ALU_SRL;
            shift        = 1'b1;
          end
          FN_SRA: begin
            b.alu_opcode = ALU_SRA;
            shift        = 1'b1;
          end
          FN_MULT: begin
            b.alu_opcode = ALU_MUL;
            b.reg_write  = 1'b0;
          end
          FN_DIV: begin
            b.alu_opcode = ALU_DIV;
            b.reg_write  = 1'b0;
          end
          default: begin
            b.illegal   = 1'b1;
            b.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        b.alu_opcode = ALU_ADD;
        itype        = 1'b1;
      end
      OP_SLTI: begin
        b.alu_opcode = ALU_SLT;
        itype        = 1'b1;
      end
      OP_ANDI: begin
        b.alu_opcode = ALU_AND;
        itype        = 1'b1;
        itype_zext   = 1'b1;
      end
      OP_ORI: begin
        b.alu_opcode = ALU_OR;
        itype        = 1'b1;
        itype_zext   = 1'b1;
      end
      OP_XORI: begin
        b.alu_opcode = ALU_XOR;
        itype        = 1'b1;
        itype_zext   = 1'b1;
      end
      OP_LUI: begin
        b.alu_opcode = ALU_LUI;
        itype        = 1'b1;
        itype_zext   = 1'b1;
      end
      // A compare against r0 lets the execute stage skip the register read of rt
      OP_BEQ: begin
        b.alu_opcode = (instr[20:16] == 5'd0) ? ALU_BEQZ : ALU_SUB;
      end
      OP_J: begin
        b.alu_opcode = ALU_J;
        b.imm        = {6'd0, instr[25:0]};
        b.src_b_sel  = SRC_B_IMM;
      end
      default: b.illegal = 1'b1;
    endcase

    if (shift) begin
      b.src_b_sel = SRC_B_SHAMT;
      b.imm       = {27'd0, instr[10:6]};
    end

    // I-type writes its result to the rt field, presented on rd
    if (itype) begin
      b.src_b_sel = SRC_B_IMM;
      b.rd        = instr[20:16];
      b.reg_write = 1'b1;
      if (itype_zext) b.imm = zext16(instr[15:0]);
    end
  end

  assign bundle = b;

endmodule

// File: rtl/mips_alu_issue.sv
// Decode/issue stage: registered ALU bundle one cycle after acceptance, held while out_ready is low.
// in_ready also drops while a MUL/DIV is in flight, counted down by a 6-bit busy counter.
module mips_alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [1:0]  src_b_sel,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  issue_bundle_t dec;
  issue_bundle_t held;
  logic [5:0]    busy;
  logic          accept;

  mips_decode u_decode (
    .instr  (in_instr),
    .bundle (dec)
  );

  assign in_ready = (!out_valid || out_ready) && (busy == 6'd0);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 6'd0;
    end else if (accept && dec.alu_opcode == ALU_MUL) begin
      busy <= MUL_LOAD;
    end else if (accept && dec.alu_opcode == ALU_DIV) begin
      busy <= DIV_LOAD;
    end else if (busy != 6'd0) begin
      busy <= busy - 6'd1;
    end
  end

  // A consume and a new accept in the same cycle simply overwrite the held bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_opcode = held.alu_opcode;
  assign rs         = held.rs;
  assign rt         = held.rt;
  assign rd         = held.rd;
  assign imm        = held.imm;
  assign src_b_sel  = held.src_b_sel;
  assign reg_write  = held.reg_write;
  assign illegal    = held.illegal;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Directed and randomized checks of mips_alu_issue against a table-driven reference decoder
// and a cycle-level handshake/stall model.
module tb_mips_alu_issue;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  logic [1:0]  src_b_sel;
  logic        reg_write;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [1:0]  sel;
    logic        rw;
    logic        ill;
  } exp_t;

  int rtab[int];
  int itab[int];

  mips_alu_issue #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .src_b_sel(src_b_sel), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: table lookups keyed by funct / opcode, then the listed special cases
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   op, fn;
    op    = int'(w[31:26]);
    fn    = int'(w[5:0]);
    e.rs  = w[25:21];
    e.rt  = w[20:16];
    e.rd  = w[15:11];
    e.imm = {{16{w[15]}}, w[15:0]};
    e.sel = 2'd0;
    e.rw  = 1'b0;
    e.ill = 1'b0;
    e.opc = 6'd0;
    if (op == 0) begin
      if (rtab.exists(fn)) begin
        e.opc = 6'(rtab[fn]);
        e.rw  = !(fn == 'h18 || fn == 'h1A);
        if (fn == 0 || fn == 2 || fn == 3) begin
          e.sel = 2'd2;
          e.imm = 32'(w[10:6]);
        end
      end else begin
        e.ill = 1'b1;
      end
    end else if (itab.exists(op)) begin
      e.opc = 6'(itab[op]);
      e.sel = 2'd1;
      e.rd  = w[20:16];
      e.rw  = 1'b1;
      if (op >= 'h0C) e.imm = 32'(w[15:0]);
    end else if (op == 4) begin
      e.opc = (w[20:16] == 5'd0) ? 6'd13 : 6'd1;
    end else if (op == 2) begin
      e.opc = 6'd17;
      e.imm = 32'(w[25:0]);
      e.sel = 2'd1;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic int lat_of(input logic [31:0] w);
    if (w[31:26] == 6'd0 && w[5:0] == 6'h18) return MUL_L;
    if (w[31:26] == 6'd0 && w[5:0] == 6'h1A) return DIV_L;
    return 1;
  endfunction

  task automatic check_bundle(input string tag, input exp_t e);
    chk({tag, "_opc"}, 32'(alu_opcode), 32'(e.opc));
    chk({tag, "_rs"}, 32'(rs), 32'(e.rs));
    chk({tag, "_rt"}, 32'(rt), 32'(e.rt));
    chk({tag, "_rd"}, 32'(rd), 32'(e.rd));
    chk({tag, "_imm"}, imm, e.imm);
    chk({tag, "_sel"}, 32'(src_b_sel), 32'(e.sel));
    chk({tag, "_rw"}, 32'(reg_write), 32'(e.rw));
    chk({tag, "_ill"}, 32'(illegal), 32'(e.ill));
  endtask

  task automatic issue(input logic [31:0] w, output int acc);
    in_valid = 1'b1;
    in_instr = w;
    #0;
    for (int k = 0; k < 100 && !in_ready; k++) tick();
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    tick();
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [5:0]  fns[15];
    logic [5:0]  ops[7];
    logic [5:0]  f, o;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02,
            6'h03, 6'h18, 6'h09, 6'h1A};
    ops = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    r   = $urandom();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        f = fns[$urandom_range(0, 13)];
        if ($urandom_range(0, 9) == 0) f = r[5:0];
        if ($urandom_range(0, 29) == 0) f = fns[14];
        return {6'd0, r[25:6], f};
      end
      4, 5, 6: begin
        o = ops[$urandom_range(0, 6)];
        return {o, r[25:0]};
      end
      7: return {6'h04, r[25:21], ($urandom_range(0, 1) == 0) ? 5'd0 : r[20:16], r[15:0]};
      8: return {6'h02, r[25:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    int   n, m, low, allow;
    logic exp_ov, exp_rdy;
    exp_t eb;

    rtab['h20] = 0;  rtab['h21] = 0;  rtab['h22] = 1;  rtab['h23] = 1;
    rtab['h24] = 8;  rtab['h25] = 9;  rtab['h26] = 10; rtab['h27] = 11;
    rtab['h2A] = 4;  rtab['h00] = 5;  rtab['h02] = 6;  rtab['h03] = 7;
    rtab['h18] = 2;  rtab['h1A] = 3;  rtab['h09] = 16;
    itab['h08] = 0;  itab['h09] = 0;  itab['h0A] = 4;  itab['h0C] = 8;
    itab['h0D] = 9;  itab['h0E] = 10; itab['h0F] = 12;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_opc", 32'(alu_opcode), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_rw", 32'(reg_write), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // add r3,r1,r2
    issue(32'h00221820, n);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_opc", 32'(alu_opcode), 32'd0);
    chk("add_rs", 32'(rs), 32'd1);
    chk("add_rt", 32'(rt), 32'd2);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_sel", 32'(src_b_sel), 32'd0);
    chk("add_rw", 32'(reg_write), 32'd1);

    // addi / andi back to back
    in_valid = 1'b1; in_instr = 32'h2005FFFF;
    #0;
    chk("addi_ready", 32'(in_ready), 32'd1);
    tick();
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(rd), 32'd5);
    in_instr = 32'h3005FFFF;
    #0;
    chk("andi_ready_nogap", 32'(in_ready), 32'd1);
    tick();
    chk("andi_imm", imm, 32'h0000FFFF);
    in_valid = 1'b0;

    // mult throttling
    issue(32'h00220018, n);
    chk("mult_opc", 32'(alu_opcode), 32'd2);
    chk("mult_rw", 32'(reg_write), 32'd0);
    in_valid = 1'b1; in_instr = 32'h00221820; low = 0;
    #0;
    for (int k = 0; k < 20 && !in_ready; k++) begin
      low++;
      tick();
    end
    tick();
    m = cyc;
    in_valid = 1'b0;
    chk("mult_stall_cycles", 32'(low), 32'd3);
    chk("mult_issue_gap", 32'(m - n), 32'(MUL_L));
    chk("mult_next_opc", 32'(alu_opcode), 32'd0);

    // div with reset during the stall
    issue(32'h0022001A, n);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("div_stall_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("div_held_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // sra held under backpressure, then beq variants
    out_ready = 1'b0;
    issue(32'h000221C3, n);
    in_valid = 1'b1; in_instr = 32'h10200010;
    for (int k = 0; k < 5; k++) begin
      #0;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_opc", 32'(alu_opcode), 32'd7);
      chk("bp_sel", 32'(src_b_sel), 32'd2);
      chk("bp_imm", imm, 32'd7);
      tick();
    end
    out_ready = 1'b1;
    #0;
    chk("swap_ready", 32'(in_ready), 32'd1);
    tick();
    chk("beqz_valid", 32'(out_valid), 32'd1);
    chk("beqz_opc", 32'(alu_opcode), 32'd13);
    chk("beqz_rw", 32'(reg_write), 32'd0);
    in_instr = 32'h10220010;
    tick();
    chk("beq_opc", 32'(alu_opcode), 32'd1);
    in_valid = 1'b0;

    // illegal and jump
    issue(32'hFC221820, n);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_opc", 32'(alu_opcode), 32'd0);
    chk("ill_rw", 32'(reg_write), 32'd0);
    check_bundle("ill", model(32'hFC221820));
    issue(32'h08123456, n);
    chk("j_opc", 32'(alu_opcode), 32'd17);
    chk("j_imm", imm, 32'h00123456);
    tick();

    // randomized phase against the cycle model
    exp_ov = 1'b0;
    allow  = cyc;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (!exp_ov || out_ready) && (cyc + 1 >= allow);
      chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (in_valid && exp_rdy) begin
        exp_ov = 1'b1;
        eb     = model(in_instr);
        allow  = cyc + lat_of(in_instr);
      end else if (out_ready) begin
        exp_ov = 1'b0;
      end
      chk("rand_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) check_bundle("rand", eb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
